// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a circular buffer of memory lines.
// Prefetches aligned lines ahead of f_eip, exposes a decode window, and flushes on redirect.
module fetch_queue #(
  parameter int                LINE_BYTES = 16,
  parameter int                DEPTH      = 4,
  parameter int                DE_BYTES   = 16,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_EIP  = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic                      imem_rdy,
  input  logic                      imem_valid,
  input  logic [8*LINE_BYTES-1:0]   imem_data,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_eip,
  input  logic                      stall,
  input  logic [$clog2(DE_BYTES):0] de_len,
  output logic                      de_vin,
  output logic                      ld_de,
  output logic [8*DE_BYTES-1:0]     f_instr,
  output logic [ADDR_W-1:0]         f_eip
);
  localparam int LB_W  = $clog2(LINE_BYTES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = $clog2(DE_BYTES) + 1;
  localparam int AV_W  = CNT_W + LB_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;
  state_t r_state, w_state_next;

  logic [8*LINE_BYTES-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0]        r_head;
  logic [CNT_W-1:0]        r_nlines;
  logic [ADDR_W-1:0]       r_eip;
  logic [ADDR_W-1:0]       r_fill_addr;

  logic [LB_W-1:0]          w_off;
  logic [AV_W-1:0]          w_avail;
  logic [LEN_W-1:0]         w_len_sat;
  logic                     w_consume;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_accept;
  logic [PTR_W-1:0]         w_tail;
  logic [PTR_W-1:0]         w_head_nx;
  logic [16*LINE_BYTES-1:0] w_pair;

  assign w_off     = r_eip[LB_W-1:0];
  assign w_avail   = {r_nlines, {LB_W{1'b0}}} - {{CNT_W{1'b0}}, w_off};
  assign w_len_sat = (de_len > LEN_W'(DE_BYTES)) ? LEN_W'(DE_BYTES) : de_len;
  assign w_tail    = r_head + PTR_W'(r_nlines);
  assign w_head_nx = r_head + PTR_W'(1);

  assign ld_de     = !stall;
  // nlines must be checked separately: with no lines and off > 0 the subtraction wraps.
  assign de_vin    = !redirect && (r_nlines != '0) && (w_avail >= AV_W'(DE_BYTES));
  assign w_consume = ld_de && de_vin;
  assign w_pop     = w_consume &&
                     (({1'b0, w_off} + (LB_W+1)'(w_len_sat)) >= (LB_W+1)'(LINE_BYTES));
  assign f_eip     = r_eip;
  assign imem_addr = r_fill_addr;

  // The window never spans more than the head line and the one after it.
  assign w_pair = {r_buf[w_head_nx], r_buf[r_head]};
  for (genvar gi = 0; gi < DE_BYTES; gi++) begin : g_win
    logic [LB_W:0] w_idx;
    assign w_idx = {1'b0, w_off} + (LB_W+1)'(gi);
    assign f_instr[8*gi +: 8] = w_pair[8*w_idx +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    w_accept     = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        imem_req = (r_nlines < CNT_W'(DEPTH)) && !redirect && !reset;
        if (imem_req && imem_rdy) begin
          w_accept     = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          w_push       = !redirect;
          w_state_next = S_IDLE;
        end else if (redirect) begin
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_valid) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_eip       <= RESET_EIP;
      r_fill_addr <= RESET_EIP & ~LINE_MASK;
      r_nlines    <= '0;
      r_head      <= '0;
    end else if (redirect) begin
      r_eip       <= redirect_eip;
      r_fill_addr <= redirect_eip & ~LINE_MASK;
      r_nlines    <= '0;
      r_head      <= '0;
    end else begin
      if (w_consume) r_eip <= r_eip + ADDR_W'(w_len_sat);
      if (w_accept)  r_fill_addr <= r_fill_addr + ADDR_W'(LINE_BYTES);
      if (w_pop)     r_head <= w_head_nx;
      if (w_push && !w_pop)      r_nlines <= r_nlines + CNT_W'(1);
      else if (!w_push && w_pop) r_nlines <= r_nlines - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_buf[w_tail] <= imem_data;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: drives fetch_queue with a latency-randomised memory and checks it
// against a queue-of-lines reference model.
module tb_fetch_queue;
  localparam int          LB      = 16;
  localparam int          DEPTH   = 4;
  localparam int          DE      = 16;
  localparam logic [31:0] RST_EIP = 32'h100;

  logic         clk = 1'b0;
  logic         reset, imem_req, imem_rdy, imem_valid, redirect, stall, de_vin, ld_de;
  logic [31:0]  imem_addr, redirect_eip, f_eip;
  logic [127:0] imem_data, f_instr;
  logic [4:0]   de_len;

  always #5 clk = ~clk;

  fetch_queue #(
    .LINE_BYTES(LB), .DEPTH(DEPTH), .DE_BYTES(DE), .ADDR_W(32), .RESET_EIP(RST_EIP)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .redirect(redirect), .redirect_eip(redirect_eip),
    .stall(stall), .de_len(de_len),
    .de_vin(de_vin), .ld_de(ld_de), .f_instr(f_instr), .f_eip(f_eip)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24];
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < LB; k++) l[8*k +: 8] = mbyte(base + 32'(k));
    return l;
  endfunction

  // Reference model: buffered line addresses plus fetch pointer and request bookkeeping.
  logic [31:0] q[$];
  logic [31:0] m_eip, m_fill, m_req_addr;
  bit          m_pending, m_wanted;
  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_lo = 0, lat_hi = 0;
  bit          rdy_rand = 0;
  // Values sampled during the most recent cycle
  bit           obs_devin, obs_req;
  logic [127:0] obs_instr;
  logic [31:0]  obs_eip, obs_addr;

  task automatic tick(input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] reip, input logic [4:0] len);
    bit          exp_req, exp_devin, resp, consume, rdy_v, mem_acc;
    int          off, avail;
    logic [4:0]  ls;
    logic [31:0] acc_addr;
    logic [127:0] win;
    exp_devin = 1'b0;
    @(negedge clk);
    reset = rst; stall = stl; redirect = rdr; redirect_eip = reip; de_len = len;
    rdy_v = rdy_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
    imem_rdy = rdy_v;
    resp = mem_busy && (mem_cnt == 0);
    imem_valid = resp;
    imem_data = resp ? mline(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    obs_devin = de_vin; obs_req = imem_req; obs_instr = f_instr;
    obs_eip = f_eip; obs_addr = imem_addr;

    exp_req = !rst && !rdr && !m_pending && (q.size() < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_fill);
    check("ld_de", ld_de, !stl);
    if (!rst) begin
      off = int'(m_eip[3:0]);
      avail = q.size() * LB - off;
      exp_devin = !rdr && (q.size() > 0) && (avail >= DE);
      check("f_eip", f_eip, m_eip);
      check("de_vin", de_vin, exp_devin);
      if (exp_devin) begin
        for (int k = 0; k < DE; k++) win[8*k +: 8] = mbyte(m_eip + 32'(k));
        check("f_instr", f_instr, win);
      end
    end
    consume  = !rst && !stl && exp_devin;
    ls       = (len > 5'd16) ? 5'd16 : len;
    mem_acc  = imem_req && rdy_v;
    acc_addr = imem_addr;

    @(posedge clk);
    if (resp)
      $display("fill addr=%h kept=%0d", mem_addr, (!rst && !rdr && m_wanted) ? 1 : 0);
    if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (resp) mem_busy = 1'b0;
    if (mem_acc) begin
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      mem_addr = acc_addr;
    end
    if (rst) begin
      q.delete();
      m_eip = RST_EIP; m_fill = RST_EIP & ~32'hF;
      m_pending = 1'b0; m_wanted = 1'b0; mem_busy = 1'b0;
    end else if (rdr) begin
      if (resp) m_pending = 1'b0;
      m_wanted = 1'b0;
      q.delete();
      m_eip = reip; m_fill = reip & ~32'hF;
    end else begin
      if (resp) begin
        m_pending = 1'b0;
        if (m_wanted) q.push_back(m_req_addr);
      end
      if (consume) begin
        if (off + int'(ls) >= LB) void'(q.pop_front());
        m_eip = m_eip + 32'(ls);
      end
      if (exp_req && rdy_v) begin
        m_pending = 1'b1; m_wanted = 1'b1;
        m_req_addr = m_fill; m_fill = m_fill + 32'(LB);
      end
    end
  endtask

  task automatic wait_devin(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
      if (obs_devin) begin
        found = 1'b1;
        n = i;
        break;
      end
    end
    if (!found) check("wait_devin_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int          n;
    logic [31:0] saved, reip;
    bit          hit;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_eip = '0; de_len = '0;
    imem_rdy = 1'b0; imem_valid = 1'b0; imem_data = '0;
    m_eip = RST_EIP; m_fill = RST_EIP; m_req_addr = '0;
    m_pending = 1'b0; m_wanted = 1'b0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;

    // Reset, first request and three-cycle window latency
    repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    check("first_req", obs_req, 1'b1);
    check("first_addr", obs_addr, 32'h100);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    check("devin_before_t3", obs_devin, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    check("devin_t3", obs_devin, 1'b1);
    check("byte0_0x100", obs_instr[7:0], mbyte(32'h100));

    // Redirect to 0x10E needs two lines; consume 3 bytes crossing into next line
    tick(1'b0, 1'b0, 1'b1, 32'h10E, 5'd0);
    wait_devin(n);
    check("devin_n5", n, 5);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd3);
    wait_devin(n);
    check("eip_0x111", obs_eip, 32'h111);
    check("byte0_0x111", obs_instr[7:0], mbyte(32'h111));

    // Stall freezes the pointer while the buffer fills up
    saved = obs_eip;
    repeat (10) tick(1'b0, 1'b1, 1'b0, 32'h0, 5'd5);
    check("stall_eip", obs_eip, saved);
    check("stall_full_no_req", obs_req, 1'b0);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd5);

    // Redirect while a response is still outstanding
    lat_lo = 2; lat_hi = 2;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_busy && mem_cnt > 0) begin hit = 1'b1; break; end
      tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd16);
    end
    check("found_wait", hit, 1'b1);
    lat_lo = 0; lat_hi = 0;
    tick(1'b0, 1'b0, 1'b1, 32'h2004, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    check("drop_no_req", obs_req, 1'b0);
    wait_devin(n);
    check("eip_0x2004", obs_eip, 32'h2004);
    check("byte0_0x2004", obs_instr[7:0], mbyte(32'h2004));

    // Redirect coinciding with a response and a would-be consume
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_busy && mem_cnt == 0) begin hit = 1'b1; break; end
      tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd16);
    end
    check("found_resp", hit, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'h3000, 5'd4);
    check("redir_devin", obs_devin, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    check("redir_empty", obs_devin, 1'b0);
    check("redir_eip", obs_eip, 32'h3000);
    check("redir_req_n1", obs_req, 1'b1);
    check("redir_addr_n1", obs_addr, 32'h3000);

    // Address wrap at the top of the space
    tick(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 5'd0);
    wait_devin(n);
    check("wrap_eip", obs_eip, 32'hFFFF_FFF8);
    check("wrap_byte8", obs_instr[71:64], mbyte(32'h0));
    check("wrap_byte15", obs_instr[127:120], mbyte(32'h7));

    // Randomised traffic
    rdy_rand = 1'b1; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      reip = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(31, 0)))
                                          : $urandom;
      tick(($urandom_range(499, 0) == 0),
           ($urandom_range(5, 0) == 0),
           ($urandom_range(39, 0) == 0),
           reip,
           5'($urandom_range(20, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
